// File: rtl/bcd_seg7_scan.sv
// Time-multiplexed 7-segment scanner for the clock display.
// Scans one BCD digit per slot with a dead-time gap, a 16-step PWM on-window,
// leading-zero blanking and per-digit decimal points. Inputs are captured once
// per frame so a digit never tears mid-scan.
module bcd_seg7_scan #(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 12000,
  parameter int BLANK_CYCLES  = 64,
  parameter int BLANK_LEADING = 1,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   bcd,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  input  logic [3:0]                brightness,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     digit_sel,
  output logic                      frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // Width of (brightness+1)*SCAN_DIV
  localparam int MW = PW + 5;

  localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);

  // Pin polarity: registers hold the pin-level value, so "off" depends on ACTIVE_LOW
  localparam logic [6:0]            SEG_POL = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_POL  = (ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] SEL_POL = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                : {NUM_DIGITS{1'b0}};

  // Scan state
  logic [PW-1:0]           prescaler_q, prescaler_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_bcd_q, snap_bcd_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                    frame_tick_q, frame_tick_d;

  // Registered pin outputs
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;

  logic                    slot_end;
  logic                    frame_end;

  // Per-digit views of the snapshot
  logic [3:0]              digit_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [NUM_DIGITS-1:0]   sel_onehot;

  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic                    cur_dp;

  // Brightness window arithmetic
  logic [MW-1:0]           on_prod;
  logic [MW-1:0]           p_ext;
  logic [MW-1:0]           p_next16;
  logic                    in_window;

  function automatic logic [6:0] seg7_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h40;  // non-BCD nibble shows a dash
    endcase
  endfunction

  assign slot_end  = (prescaler_q == P_LAST);
  assign frame_end = slot_end && (idx_q == I_LAST);

  // Per-digit nibble split, one-hot select and leading-zero flags
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_nib[gi]  = snap_bcd_q[4*gi +: 4];
    assign sel_onehot[gi] = (idx_q == IW'(gi));
    if (gi == 0 || BLANK_LEADING == 0) begin : g_noblank
      assign blank_vec[gi] = 1'b0;
    end else begin : g_blank
      // Blank when this digit and every digit above it are zero
      assign blank_vec[gi] = (snap_bcd_q[4*NUM_DIGITS-1:4*gi] == '0);
    end
  end

  assign cur_nib   = digit_nib[idx_q];
  assign cur_blank = blank_vec[idx_q];
  assign cur_dp    = snap_dp_q[idx_q];

  // on_end = max(BLANK_CYCLES+1, on_prod>>4). Rather than shifting, the upper
  // bound is tested as on_prod >= 16*(prescaler+1), which is equivalent to
  // prescaler < floor(on_prod/16); the first lit cycle is always allowed.
  assign on_prod  = ({{(MW-4){1'b0}}, brightness} + MW'(1)) * MW'(SCAN_DIV);
  assign p_ext    = {5'b00000, prescaler_q};
  assign p_next16 = (p_ext + MW'(1)) << 4;
  assign in_window = (prescaler_q >= P_BLANK) &&
                     ((prescaler_q == P_BLANK) || (on_prod >= p_next16));

  // Next-state for prescaler, digit index, frame snapshot and frame tick
  always_comb begin
    prescaler_d  = prescaler_q + PW'(1);
    idx_d        = idx_q;
    snap_bcd_d   = snap_bcd_q;
    snap_dp_d    = snap_dp_q;
    frame_tick_d = frame_end;
    if (slot_end) begin
      prescaler_d = '0;
      idx_d       = (idx_q == I_LAST) ? '0 : idx_q + IW'(1);
    end
    if (frame_end) begin
      snap_bcd_d = bcd;
      snap_dp_d  = dp_mask;
    end
  end

  // Next pin values: segments always track the current digit, select only in the window
  always_comb begin
    seg_d = (cur_blank ? 7'h00 : seg7_decode(cur_nib)) ^ SEG_POL;
    dp_d  = cur_dp ^ DP_POL;
    sel_d = (in_window ? sel_onehot : '0) ^ SEL_POL;
  end

  // Scan state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_q  <= '0;
      idx_q        <= '0;
      snap_bcd_q   <= '0;
      snap_dp_q    <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      idx_q        <= idx_d;
      snap_bcd_q   <= snap_bcd_d;
      snap_dp_q    <= snap_dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Output registers: seg, dp and digit_sel all update on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= SEG_POL;
      dp_q  <= DP_POL;
      sel_q <= SEL_POL;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      sel_q <= sel_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_sel  = sel_q;
  assign frame_tick = frame_tick_q;

endmodule
